muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 151 +++++++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per
// RUN cycle on operand magnitudes, with signs re-applied when the result is written.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [2:0]       r_op;
    logic             r_neg, r_special, r_dbz_pend;
    logic [WIDTH-1:0] r_hi, r_lo, r_b;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_div_by_zero;

    logic             w_accept;
    logic             w_sa, w_sb, w_a_neg, w_b_neg, w_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;
    logic             w_dbz, w_ovf;
    logic [WIDTH-1:0] w_spec_res;
    logic [WIDTH:0]   w_sum, w_trial, w_diff;
    logic             w_borrow;
    logic [2*WIDTH-1:0] w_prod, w_prod_s;
    logic [WIDTH-1:0] w_quo, w_rem, w_final;
    logic             w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_cnt == CW'(WIDTH));

    // Operand classification, sampled only at the accepting edge
    assign w_sa    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign w_sb    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign w_a_neg = w_sa && operand_a[WIDTH-1];
    assign w_b_neg = w_sb && operand_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -operand_a : operand_a;
    assign w_b_mag = w_b_neg ? -operand_b : operand_b;
    assign w_neg   = (op == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_dbz = op[2] && (operand_b == '0);
    assign w_ovf = op[2] && !op[0] && (operand_a == {1'b1, {(WIDTH-1){1'b0}}})
                   && (operand_b == '1);
    assign w_spec_res = w_dbz ? (op[1] ? operand_a : '1) : (op[1] ? '0 : operand_a);

    // Multiply step: r_hi accumulates, r_lo shifts out multiplier bits
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    // Divide step: r_hi holds the partial remainder, r_lo shifts dividend out / quotient in
    assign w_trial  = {r_hi, r_lo[WIDTH-1]};
    assign w_diff   = w_trial - {1'b0, r_b};
    assign w_borrow = w_diff[WIDTH];

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg ? -w_prod : w_prod;
    assign w_quo    = r_neg ? -r_lo : r_lo;
    assign w_rem    = r_neg ? -r_hi : r_hi;

    always_comb begin
        w_final = '0;
        case (r_op)
            3'b000:                 w_final = w_prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_final = w_quo;
            default:                w_final = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Special cases spend a single RUN cycle so done arrives one edge after accept
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_special || w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op          <= '0;
            r_neg         <= 1'b0;
            r_special     <= 1'b0;
            r_dbz_pend    <= 1'b0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_b           <= '0;
            r_cnt         <= '0;
            r_result      <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_op          <= op;
            r_neg         <= w_neg;
            r_special     <= w_dbz || w_ovf;
            r_dbz_pend    <= w_dbz;
            r_div_by_zero <= 1'b0;
            r_cnt         <= '0;
            r_hi          <= '0;
            if (op[2]) begin
                r_lo <= (w_dbz || w_ovf) ? w_spec_res : w_a_mag;
                r_b  <= w_b_mag;
            end else begin
                r_lo <= w_b_mag;
                r_b  <= w_a_mag;
            end
        end else if (r_state == S_RUN) begin
            if (r_special) begin
                r_result      <= r_lo;
                r_div_by_zero <= r_dbz_pend;
            end else if (!w_last) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_op[2]) begin
                    r_hi <= w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], ~w_borrow};
                end else begin
                    r_hi <= w_sum[WIDTH:1];
                    r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
                end
            end else begin
                r_result <= w_final;
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign result      = r_result;
    assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [2:0]    op;
    logic [W-1:0]  operand_a, operand_b;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  result;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, output bit dbz, output bit spec);
        longint          sa = longint'(signed'(a));
        longint          sb = longint'(signed'(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          p;
        longint unsigned up;
        bit              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        logic [31:0]     r;
        dbz = 0;
        spec = 0;
        r = '0;
        case (o)
            3'd0: begin up = ua * ub; r = up[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin up = ua * ub; r = up[63:32]; end
            3'd4: if (b == 0) begin dbz = 1; spec = 1; r = '1; end
                  else if (ovf) begin spec = 1; r = a; end
                  else r = 32'(sa / sb);
            3'd5: if (b == 0) begin dbz = 1; spec = 1; r = '1; end
                  else r = 32'(ua / ub);
            3'd6: if (b == 0) begin dbz = 1; spec = 1; r = a; end
                  else if (ovf) begin spec = 1; r = '0; end
                  else r = 32'(sa % sb);
            default: if (b == 0) begin dbz = 1; spec = 1; r = a; end
                     else r = 32'(ua % ub);
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit noise, input string tag);
        logic [31:0] exp, prev;
        bit          edbz, espec, held;
        int          n, nbusy;
        exp = model(o, a, b, edbz, espec);
        @(negedge clk);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        prev = result;
        held = 1'b1;
        @(posedge clk); #1;
        start = noise ? 1'($urandom) : 1'b0;
        op = 3'($urandom); operand_a = 32'($urandom); operand_b = 32'($urandom);
        chk({tag, " dbz_clr"}, 64'(div_by_zero), 64'(0));
        n = 0;
        nbusy = busy ? 1 : 0;
        while (!done && n < 100) begin
            if (result !== prev) held = 1'b0;
            @(posedge clk); #1;
            n++;
            if (busy) nbusy++;
            if (noise && !done) begin
                start = 1'($urandom);
                op = 3'($urandom); operand_a = 32'($urandom); operand_b = 32'($urandom);
            end
        end
        start = 1'b0;
        chk({tag, " latency"}, 64'(n), espec ? 64'(1) : 64'(33));
        chk({tag, " busy_cycles"}, 64'(nbusy), espec ? 64'(2) : 64'(34));
        chk({tag, " no_intermediate"}, 64'(held), 64'(1));
        chk({tag, " result"}, 64'(result), 64'(exp));
        chk({tag, " dbz"}, 64'(div_by_zero), 64'(edbz));
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, 64'(done), 64'(0));
        chk({tag, " idle"}, 64'(busy), 64'(0));
        chk({tag, " hold"}, 64'(result), 64'(exp));
        chk({tag, " hold_dbz"}, 64'(div_by_zero), 64'(edbz));
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'(0));
        chk("rst done", 64'(done), 64'(0));
        chk("rst result", 64'(result), 64'(0));
        chk("rst dbz", 64'(div_by_zero), 64'(0));

        // rst and start together: reset wins
        @(negedge clk);
        start = 1'b1; op = 3'd0; operand_a = 32'd3; operand_b = 32'd4;
        @(posedge clk); #1;
        chk("rst_over_start busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b0; start = 1'b0;

        run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 0, "mul");
        run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 0, "mulh");
        run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         0, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         0, "div");
        run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         0, "rem");
        run_op(3'd5, 32'hFFFF_FFF9,  32'd2,         0, "divu");
        run_op(3'd5, 32'd5,          32'd0,         0, "divu_z");
        run_op(3'd7, 32'd5,          32'd0,         0, "remu_z");
        run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0, "div_ovf");
        run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0, "rem_ovf");
        run_op(3'd4, 32'd9,          32'd0,         0, "div_z");
        run_op(3'd0, 32'd3,          32'd4,         1, "mul_noise");

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), pick(), pick(), 1'($urandom), $sformatf("rnd%0d", i));
        end

        // Reset on the 10th RUN cycle of a DIV aborts it silently
        run_op(3'd0, 32'd11, 32'd13, 0, "pre_abort");
        @(negedge clk);
        op = 3'd4; operand_a = 32'h1234_5678; operand_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort result", 64'(result), 64'(0));
        chk("abort dbz", 64'(div_by_zero), 64'(0));
        rst = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort no_done", 64'(ndone), 64'(0));
        run_op(3'd5, 32'd100, 32'd7, 0, "divu_after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
